// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: frame constants, FSM state encoding, frame bit selection.
// Latency: n/a (package only, no logic of its own).
// Backpressure: n/a.
// Contents: PS2_FRAME_BITS, PS2_START, PS2_STOP, ps2_state_e, ps2_frame_bit().
package ps2_pkg;

  localparam int   PS2_FRAME_BITS = 11;
  localparam logic PS2_START      = 1'b0;
  localparam logic PS2_STOP       = 1'b1;

  // Line-level FSM states, shared with the host-side transmitter.
  typedef enum logic [1:0] {
    PS2_IDLE = 2'd0,
    PS2_HIGH = 2'd1,
    PS2_LOW  = 2'd2,
    PS2_GAP  = 2'd3
  } ps2_state_e;

  // Value of frame bit idx (0..10) for byte d: start, d[0..7], odd parity, stop.
  function automatic logic ps2_frame_bit(input logic [7:0] d, input logic [3:0] idx);
    logic [2:0] k;
    logic       b;
    k = 3'(idx - 4'd1);
    case (idx)
      4'd0:                                            b = PS2_START;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8:  b = d[k];
      4'd9:                                            b = ~^d;
      default:                                         b = PS2_STOP;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO whose head is read in place (first-word fall-through).
// Latency: a push is visible at head/empty one cycle after the push edge.
// Backpressure: full blocks push; pop on empty is ignored.
// Ports: clk, rst (async high), push/din, pop, full, empty, head.
module ps2_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer MSB separates full (wrapped once) from empty (equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// Device-side PS/2 transmitter: buffers scan-code bytes and sends 11-bit frames on ps2_clk/ps2_data.
// Latency: start bit on the lines one cycle after a push into an idle, empty FIFO; frame 22*CLK_HALF cycles.
// Backpressure: tx_ready low while the FIFO is full; host inhibit aborts a frame, which is resent whole.
// Ports: clk, rst, tx_data/tx_valid/tx_ready, inhibit, ps2_clk, ps2_data, busy, tx_done.
module ps2_keyboard_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HALF = 4,
  parameter int GAP      = 8,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       tx_done
);

  localparam int MAXC  = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int CNT_W = $clog2(MAXC);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP - 1);

  ps2_state_e       state_q, state_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_d;
  logic             clk_d;
  logic             data_d;
  logic             pop;
  logic             full;
  logic             empty;
  logic [7:0]       head;

  ps2_tx_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign tx_ready = !full;
  assign busy     = (state_q != PS2_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PS2_IDLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      ps2_clk  <= clk_d;
      ps2_data <= data_d;
      tx_done  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      PS2_IDLE: begin
        if (!empty && !inhibit) begin
          state_d = PS2_HIGH;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      PS2_HIGH: begin
        if (inhibit) begin
          state_d = PS2_GAP;
          cnt_d   = '0;
        end else if (cnt_q == HALF_END) begin
          state_d = PS2_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PS2_LOW: begin
        // An abort wins over completion, so the byte stays queued for a resend.
        if (inhibit) begin
          state_d = PS2_GAP;
          cnt_d   = '0;
        end else if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = PS2_GAP;
            pop     = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = PS2_HIGH;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PS2_GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = PS2_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = PS2_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Lines are registered from the next state, so data changes on the first HIGH cycle
    // and is held through LOW; all other states leave both lines released high.
    clk_d  = (state_d != PS2_LOW);
    data_d = ((state_d == PS2_HIGH) || (state_d == PS2_LOW)) ? ps2_frame_bit(head, bit_d) : 1'b1;
  end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Self-checking bench for ps2_keyboard_tx: directed plus random bytes against a frame-level model.
// Latency: n/a.
// Backpressure: exercises full FIFO, host inhibit abort and reset mid-frame.
module tb_ps2_keyboard_tx;

  localparam int CH  = 4;
  localparam int GP  = 8;
  localparam int DP  = 8;
  localparam int FRAME_PERIOD = 22 * CH + GP + 1;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       inhibit;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       tx_done;

  ps2_keyboard_tx #(.CLK_HALF(CH), .GAP(GP), .DEPTH(DP)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .inhibit  (inhibit),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Reference model state: bytes accepted and not yet seen on the wire.
  logic [7:0]  exp_q[$];
  // Receiver-side observations.
  logic [10:0] rx_q[$];
  int          fall_q[$];
  int          done_q[$];
  int          done_cnt = 0;

  // Loopback PS/2 receiver: sample data on each ps2_clk fall; a long clock-high
  // stretch discards a partial (aborted) frame.
  logic        prev_clk = 1'b1;
  int          bitcnt = 0;
  int          since = 0;
  logic [10:0] shreg = '0;
  always @(negedge clk) begin
    if (rst) begin
      bitcnt   = 0;
      since    = 0;
      prev_clk = 1'b1;
    end else begin
      if (prev_clk && !ps2_clk) begin
        if (bitcnt == 0) fall_q.push_back(cyc);
        shreg[bitcnt] = ps2_data;
        bitcnt++;
        since = 0;
        if (bitcnt == 11) begin
          rx_q.push_back(shreg);
          bitcnt = 0;
        end
      end else begin
        since++;
        if (since > 2 * CH + 2) bitcnt = 0;
      end
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_q.push_back(cyc);
      end
      prev_clk = ps2_clk;
    end
  end

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int          ones;
    logic [10:0] f;
    ones = 0;
    f    = '0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = d[i];
      if (d[i]) ones++;
    end
    f[0]  = 1'b0;
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one byte for one edge; k is the edge it was offered on.
  task automatic send(input logic [7:0] d, output int k, output logic acc);
    tx_valid = 1'b1;
    tx_data  = d;
    acc      = tx_ready;
    tick();
    k = cyc;
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int b;
    b = 0;
    while (rx_q.size() < n && b < n * 250) begin
      tick();
      b++;
    end
    chk({tag, "_rx_timeout"}, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic drain(input int n, input string tag);
    logic [10:0] got;
    logic [7:0]  e;
    wait_rx(n, tag);
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() == 0 || exp_q.size() == 0) begin
        chk({tag, "_queue_empty"}, 32'(rx_q.size()), 32'(exp_q.size()));
        break;
      end
      got = rx_q.pop_front();
      e   = exp_q.pop_front();
      chk({tag, "_frame"}, 32'(got), 32'(model_frame(e)));
    end
  endtask

  task automatic wait_idle(input string tag);
    int b;
    b = 0;
    while (busy !== 1'b0 && b < 1000) begin
      tick();
      b++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   k, k0, d0;
    logic acc;

    rst      = 1'b1;
    tx_data  = '0;
    tx_valid = 1'b0;
    inhibit  = 1'b0;
    repeat (3) tick();
    chk("rst_ps2_clk",  32'(ps2_clk),  32'd1);
    chk("rst_ps2_data", 32'(ps2_data), 32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tx_done",  32'(tx_done),  32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single byte 0x1C: timing of start bit, first fall and tx_done.
    fall_q.delete();
    done_q.delete();
    d0 = done_cnt;
    send(8'h1C, k, acc);
    tx_valid = 1'b0;
    tick();
    chk("start_busy", 32'(busy),     32'd1);
    chk("start_data", 32'(ps2_data), 32'd0);
    chk("start_clk",  32'(ps2_clk),  32'd1);
    wait_rx(1, "single");
    chk("single_bits", 32'(rx_q[0]), 32'h438);
    drain(1, "single");
    wait_idle("single");
    chk("single_first_fall", 32'(fall_q.size() > 0 ? fall_q[0] : -1), 32'(k + 1 + CH));
    chk("single_done_cnt",   32'(done_cnt - d0), 32'd1);
    chk("single_done_time",  32'(done_q.size() > 0 ? done_q[0] : -1), 32'(k + 1 + 22 * CH));

    // Parity: 0xF0 has an even number of ones, so the odd-parity bit is 1.
    send(8'hF0, k, acc);
    tx_valid = 1'b0;
    wait_rx(1, "parity");
    chk("parity_f0", 32'(rx_q.size() > 0 ? rx_q[0][9] : 1'bx), 32'd1);
    drain(1, "parity");
    wait_idle("parity");

    // Burst of three directed bytes plus three random ones, back to back.
    fall_q.delete();
    send(8'h1C, k, acc);
    send(8'hF0, k, acc);
    send(8'h1C, k, acc);
    for (int i = 0; i < 3; i++) send(8'($urandom), k, acc);
    tx_valid = 1'b0;
    drain(6, "burst");
    wait_idle("burst");
    for (int i = 1; i < 6; i++) begin
      chk("burst_spacing", 32'(i < fall_q.size() ? fall_q[i] - fall_q[i-1] : -1), 32'(FRAME_PERIOD));
    end

    // Random bytes with random spacing.
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom), k, acc);
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 150)) tick();
    end
    drain(5, "random");
    wait_idle("random");

    // Full: inhibit holds the FSM idle while nine bytes are offered.
    inhibit = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      send(8'($urandom), k, acc);
      chk("full_accept", 32'(acc), 32'(i < DP));
    end
    tx_valid = 1'b0;
    tick();
    chk("full_ready_low", 32'(tx_ready), 32'd0);
    chk("full_held_idle", 32'(busy), 32'd0);
    d0 = done_cnt;
    inhibit = 1'b0;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      tick();
      k++;
    end
    chk("full_first_done", 32'(done_cnt - d0), 32'd1);
    chk("full_ready_rise", 32'(tx_ready), 32'd1);
    drain(DP, "full");
    wait_idle("full");

    // Abort: inhibit during the bit-5 LOW phase of 0xA5.
    d0 = done_cnt;
    send(8'hA5, k, acc);
    tx_valid = 1'b0;
    while (cyc < k + 1 + 11 * CH + 1) tick();
    chk("abort_in_low", 32'(ps2_clk), 32'd0);
    inhibit = 1'b1;
    tick();
    chk("abort_clk_high",  32'(ps2_clk),  32'd1);
    chk("abort_data_high", 32'(ps2_data), 32'd1);
    repeat (20) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_idle",    32'(busy), 32'd0);
    chk("abort_no_rx",   32'(rx_q.size()), 32'd0);
    inhibit = 1'b0;
    drain(1, "abort");
    wait_idle("abort");
    repeat (50) tick();
    chk("abort_done_once", 32'(done_cnt - d0), 32'd1);
    chk("abort_rx_once",   32'(rx_q.size()), 32'd0);

    // Reset mid-frame with three bytes queued behind the one on the wire.
    send(8'($urandom), k0, acc);
    for (int i = 0; i < 3; i++) send(8'($urandom), k, acc);
    tx_valid = 1'b0;
    while (cyc < k0 + 1 + CH + 1) tick();
    chk("reset_in_low", 32'(ps2_clk), 32'd0);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    chk("reset_clk",   32'(ps2_clk),  32'd1);
    chk("reset_data",  32'(ps2_data), 32'd1);
    chk("reset_busy",  32'(busy),     32'd0);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    repeat (300) tick();
    chk("reset_no_frame", 32'(rx_q.size()), 32'd0);
    chk("reset_no_done",  32'(done_cnt - d0), 32'd0);
    chk("reset_stay_idle", 32'(busy), 32'd0);
    chk("reset_line_clk", 32'(ps2_clk), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
